wired_bus_arbiter: RTL and testbench
====================================

# wired_bus_arbiter

Parametrised wired-logic bus arbiter: N channels each shift a fixed-width ID onto one shared open-drain-style line, MSB first, resolved as wired-AND or wired-OR. A channel that drives the recessive level but reads the dominant level drops out. After ID_W bit-times exactly one channel holds the grant. It is the sequential, multi-channel successor to the team's single-net wand resolver, and it arbitrates access to shared-bus resources.

## Interface
Parameters:
- N_CH, 4, number of requesting channels (≥2)
- ID_W, 4, ID width in bits (≥1)
- DOMINANT, 0, dominant bus level; 0 = wired-AND (lowest ID wins), 1 = wired-OR (highest ID wins)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin an arbitration round
- req  in  N_CH  per-channel participation, sampled with start
- id  in  N_CH*ID_W  channel c's ID in bits [c*ID_W +: ID_W], sampled with start
- bus  out  1  resolved line value for the current bit-time
- busy  out  1  arbitration round in progress
- done  out  1  one-cycle pulse, round complete
- grant  out  N_CH  one-hot winner, held until the next accepted start or rst
- win_id  out  ID_W  winner's ID, held with grant
- lost  out  N_CH  channels eliminated so far in this round (sticky within the round)

## Operation
- States: IDLE, ARB, DONE.
- IDLE:
  - start=1 and req≠0 → latch req into the active mask and id into per-channel shift registers; clear grant, win_id and lost; set the bit counter to ID_W-1; go to ARB.
  - start with req=0 is ignored.
- ARB, each cycle:
  - Each active channel drives its current MSB. Inactive and lost channels drive the recessive level (~DOMINANT).
  - bus = AND of the drives (DOMINANT=0) or OR of the drives (DOMINANT=1).
  - An active channel whose bit ≠ bus is cleared from active and set in lost at the clock edge.
  - Shift registers shift left and the counter decrements. When the counter reaches 0, go to DONE at the next edge.
- DONE, one cycle:
  - done=1. grant = surviving mask reduced to its lowest-index set bit (tie-break for duplicate IDs); the other survivors are set in lost. win_id = the winner's latched ID.
  - Go to IDLE.
- start while busy or in DONE is ignored; no queueing.
- bus = recessive whenever not in ARB.
- Reset values: busy=0, done=0, grant=0, win_id=0, lost=0, bus=~DOMINANT, state IDLE.
- rst mid-round aborts immediately to the reset values. No partial grant is issued.

## Timing
- start accepted at edge T. busy=1 and ARB bit-times run during cycles T+1 … T+ID_W.
- The DONE cycle is T+ID_W+1: done=1 and busy=0. grant and win_id are valid from that cycle.
- Earliest next accepted start is in the DONE cycle's following edge, giving a round period of ID_W+2 cycles.
- bus is combinational from the registered state within an ARB cycle. lost updates at the edge ending the bit-time in which the mismatch occurred.

## Structure
- Package wired_bus_pkg: state enum (IDLE, ARB, DONE) and the localparams DOM_LOW=0 and DOM_HIGH=1.
- Sub-module wired_resolve: combinational N-input wand/wor reduction parametrised by N and DOMINANT, feeding bus.
- The top-level holds the FSM, counter, shift registers, masks and tie-break priority encoder.

## Test plan
All scenarios use N_CH=4 and ID_W=4 unless stated.
- DOMINANT=0, req=4'b1111, IDs ch0..ch3=A,3,5,C, start → bus bits 0,0,1,1; lost after bit3 = 4'b1001, after bit2 = 4'b1101; done at T+5; grant=4'b0010, win_id=3.
- Duplicate IDs: DOMINANT=0, req=4'b1010, ch1=ch3=3 → grant=4'b0010, win_id=3, lost=4'b1000 in the DONE cycle.
- Single requester: req=4'b1000, ch3=F → bus bits 1,1,1,1; grant=4'b1000, win_id=F, lost=0.
- DOMINANT=1, IDs as in the first scenario, req=4'b1111 → grant=4'b1000, win_id=C.
- rst asserted at T+2 → next cycle busy=0, done=0, grant=0, lost=0, bus=recessive; a fresh start then completes normally.
- start with req=0 → no busy. A second start at T+2 during a round → ignored; exactly one done pulse.

Source files
------------

// File: rtl/wired_bus_pkg.sv
// Shared definitions for the wired-logic bus arbiter.
// Contents: FSM state encoding and the two dominant-level encodings.
package wired_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Dominant level: DOM_LOW gives wired-AND, DOM_HIGH gives wired-OR.
  localparam logic DOM_LOW  = 1'b0;
  localparam logic DOM_HIGH = 1'b1;

endpackage

// File: rtl/wired_resolve.sv
// Combinational N-input wired-AND / wired-OR line resolver.
// Ports: drv  - one drive level per channel
//        res_c - resolved line level (AND when DOMINANT=0, OR when DOMINANT=1)
module wired_resolve
  import wired_bus_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter logic        DOMINANT = DOM_LOW
) (
  input  logic [N-1:0] drv,
  output logic         res_c
);

  // A single dominant driver pulls the whole line to the dominant level.
  if (DOMINANT == DOM_LOW) begin : g_wand
    assign res_c = &drv;
  end else begin : g_wor
    assign res_c = |drv;
  end

endmodule

// File: rtl/wired_bus_arbiter.sv
// Bit-serial wired-logic arbiter: channels shift IDs MSB first onto a shared
// line and drop out when they drive recessive but read dominant.
// Ports: clk, rst (sync, active-high); start/req/id request a round;
//        bus - resolved line (combinational from state); busy - round running;
//        done - one-cycle completion pulse; grant/win_id - held winner;
//        lost - channels eliminated in the current round.
module wired_bus_arbiter
  import wired_bus_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned ID_W     = 4,
  parameter logic        DOMINANT = DOM_LOW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_CH-1:0]      req,
  input  logic [N_CH*ID_W-1:0] id,
  output logic                 bus,
  output logic                 busy,
  output logic                 done,
  output logic [N_CH-1:0]      grant,
  output logic [ID_W-1:0]      win_id,
  output logic [N_CH-1:0]      lost
);

  localparam int unsigned CNT_W = (ID_W > 1) ? $clog2(ID_W) : 1;

  state_t                       state, state_nxt;
  logic                         accept;
  logic [N_CH-1:0]              active;
  logic [N_CH-1:0][ID_W-1:0]    sh;
  logic [CNT_W-1:0]             cnt;
  logic [ID_W-1:0]              id_acc;
  logic [N_CH-1:0]              drive;
  logic [N_CH-1:0]              mism;
  logic [N_CH-1:0]              surv;
  logic [N_CH-1:0]              first;

  // Per-channel drive: MSB of the shift register while active, recessive otherwise.
  always_comb begin
    drive = {N_CH{~DOMINANT}};
    for (int c = 0; c < N_CH; c++) begin
      if ((state == ARB) && active[c]) drive[c] = sh[c][ID_W-1];
    end
  end

  wired_resolve #(.N(N_CH), .DOMINANT(DOMINANT)) u_resolve (
    .drv   (drive),
    .res_c (bus)
  );

  // Elimination and lowest-index tie-break among the survivors.
  always_comb begin
    mism = '0;
    for (int c = 0; c < N_CH; c++) begin
      mism[c] = active[c] & (sh[c][ID_W-1] ^ bus);
    end
    surv  = active & ~mism;
    first = surv & (~surv + N_CH'(1));
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start && (|req)) begin
          accept    = 1'b1;
          state_nxt = ARB;
        end
      end
      ARB:     if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      grant  <= '0;
      win_id <= '0;
      lost   <= '0;
      active <= '0;
      sh     <= '0;
      cnt    <= '0;
      id_acc <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ARB);
      done  <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            active <= req;
            sh     <= id;
            grant  <= '0;
            win_id <= '0;
            lost   <= '0;
            cnt    <= CNT_W'(ID_W - 1);
            id_acc <= '0;
          end
        end
        ARB: begin
          active <= surv;
          lost   <= lost | mism;
          for (int c = 0; c < N_CH; c++) sh[c] <= sh[c] << 1;
          cnt    <= cnt - CNT_W'(1);
          // The winner always matches the line, so the bus history is its ID.
          id_acc <= (id_acc << 1) | ID_W'(bus);
          if (cnt == '0) begin
            grant  <= first;
            win_id <= (id_acc << 1) | ID_W'(bus);
            lost   <= lost | mism | (surv & ~first);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wired_bus_arbiter.sv
// Self-checking bench for wired_bus_arbiter: one wired-AND and one wired-OR
// instance share stimulus; table vectors plus directed multi-cycle sequences.
module tb_wired_bus_arbiter;

  localparam int unsigned N_CH = 4;
  localparam int unsigned ID_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  req;
  logic [15:0] id;

  logic        bus0, busy0, done0, bus1, busy1, done1;
  logic [3:0]  grant0, win0, lost0, grant1, win1, lost1;

  int total = 0;
  int bad   = 0;

  logic [3:0] bus0_bits, bus1_bits, busy_hist;
  logic [3:0] lost_hist [ID_W];

  always #5 clk = ~clk;

  wired_bus_arbiter #(.N_CH(N_CH), .ID_W(ID_W), .DOMINANT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .req(req), .id(id),
    .bus(bus0), .busy(busy0), .done(done0), .grant(grant0),
    .win_id(win0), .lost(lost0)
  );

  wired_bus_arbiter #(.N_CH(N_CH), .ID_W(ID_W), .DOMINANT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .req(req), .id(id),
    .bus(bus1), .busy(busy1), .done(done1), .grant(grant1),
    .win_id(win1), .lost(lost1)
  );

  typedef struct {
    logic [3:0]  req;
    logic [15:0] id;
    logic [3:0]  bus0, g0, w0, l0;
    logic [3:0]  bus1, g1, w1, l1;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start a round and sample every ARB cycle; returns at the DONE-cycle negedge.
  task automatic run_round(input logic [3:0] r, input logic [15:0] i);
    @(negedge clk);
    start = 1'b1; req = r; id = i;
    @(posedge clk);
    #1 start = 1'b0; req = '0;
    for (int b = 0; b < ID_W; b++) begin
      @(negedge clk);
      bus0_bits    = {bus0_bits[2:0], bus0};
      bus1_bits    = {bus1_bits[2:0], bus1};
      busy_hist[b] = busy0 & busy1;
      lost_hist[b] = lost0;
    end
    @(negedge clk);
  endtask

  initial begin
    int ndone;
    // id packs {ch3, ch2, ch1, ch0}
    vt[0] = '{4'b1111, 16'hC53A, 4'b0011, 4'b0010, 4'h3, 4'b1101,
                                 4'b1100, 4'b1000, 4'hC, 4'b0111};
    vt[1] = '{4'b1010, 16'h3030, 4'b0011, 4'b0010, 4'h3, 4'b1000,
                                 4'b0011, 4'b0010, 4'h3, 4'b1000};
    vt[2] = '{4'b1000, 16'hF000, 4'b1111, 4'b1000, 4'hF, 4'b0000,
                                 4'b1111, 4'b1000, 4'hF, 4'b0000};
    vt[3] = '{4'b0101, 16'hC53A, 4'b0101, 4'b0100, 4'h5, 4'b0001,
                                 4'b1010, 4'b0001, 4'hA, 4'b0100};
    vt[4] = '{4'b0110, 16'h0670, 4'b0110, 4'b0100, 4'h6, 4'b0010,
                                 4'b0111, 4'b0010, 4'h7, 4'b0100};

    rst = 1'b1; start = 1'b0; req = '0; id = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset busy",  32'(busy0),  32'd0);
    chk("reset done",  32'(done0),  32'd0);
    chk("reset grant", 32'(grant0), 32'd0);
    chk("reset win",   32'(win0),   32'd0);
    chk("reset lost",  32'(lost0),  32'd0);
    chk("reset bus0",  32'(bus0),   32'd1);
    chk("reset bus1",  32'(bus1),   32'd0);

    for (int v = 0; v < 5; v++) begin
      run_round(vt[v].req, vt[v].id);
      chk($sformatf("v%0d bus0", v),  32'(bus0_bits), 32'(vt[v].bus0));
      chk($sformatf("v%0d bus1", v),  32'(bus1_bits), 32'(vt[v].bus1));
      chk($sformatf("v%0d busy", v),  32'(busy_hist), 32'hF);
      chk($sformatf("v%0d done", v),  32'({done0, done1, busy0, busy1}), 32'b1100);
      chk($sformatf("v%0d grant0", v), 32'(grant0), 32'(vt[v].g0));
      chk($sformatf("v%0d win0", v),   32'(win0),   32'(vt[v].w0));
      chk($sformatf("v%0d lost0", v),  32'(lost0),  32'(vt[v].l0));
      chk($sformatf("v%0d grant1", v), 32'(grant1), 32'(vt[v].g1));
      chk($sformatf("v%0d win1", v),   32'(win1),   32'(vt[v].w1));
      chk($sformatf("v%0d lost1", v),  32'(lost1),  32'(vt[v].l1));
    end

    // Sticky lost progression within a round, then held results afterwards.
    run_round(4'b1111, 16'hC53A);
    chk("lost bit-time 1", 32'(lost_hist[0]), 32'b0000);
    chk("lost after bit3", 32'(lost_hist[1]), 32'b1001);
    chk("lost after bit2", 32'(lost_hist[2]), 32'b1101);
    @(negedge clk);
    chk("post done pulse", 32'(done0), 32'd0);
    chk("grant held", 32'(grant0), 32'b0010);
    chk("idle bus", 32'(bus0), 32'd1);

    // start with req=0 is ignored and leaves the previous grant in place.
    start = 1'b1; req = '0; id = 16'hFFFF;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("req0 busy", 32'(busy0), 32'd0);
    chk("req0 grant held", 32'(grant0), 32'b0010);
    chk("req0 win held", 32'(win0), 32'h3);

    // rst two cycles into a round aborts with no grant and no late done.
    @(negedge clk);
    start = 1'b1; req = 4'b1111; id = 16'hC53A;
    @(posedge clk);
    #1 start = 1'b0; req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort busy",  32'(busy0),  32'd0);
    chk("abort done",  32'(done0),  32'd0);
    chk("abort grant", 32'(grant0), 32'd0);
    chk("abort lost",  32'(lost0),  32'd0);
    chk("abort bus0",  32'(bus0),   32'd1);
    chk("abort bus1",  32'(bus1),   32'd0);
    ndone = 0;
    for (int k = 0; k < ID_W + 2; k++) begin
      @(negedge clk);
      if (done0 || busy0) ndone++;
    end
    chk("abort no activity", 32'(ndone), 32'd0);
    run_round(4'b1111, 16'hC53A);
    chk("fresh grant", 32'(grant0), 32'b0010);
    chk("fresh win",   32'(win0),   32'h3);

    // A second start two cycles into a round is ignored: one done pulse only.
    @(negedge clk);
    start = 1'b1; req = 4'b1111; id = 16'hC53A;
    @(posedge clk);
    #1 start = 1'b0; req = '0;
    ndone = 0;
    for (int k = 0; k < 3 * ID_W; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b1; req = 4'b0001; id = 16'h0000;
      end else begin
        start = 1'b0; req = '0;
      end
      if (done0) ndone++;
    end
    chk("single done pulse", 32'(ndone), 32'd1);
    chk("ignored start grant", 32'(grant0), 32'b0010);
    chk("ignored start win",   32'(win0),   32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
